// File: rtl/countdown_arbiter.sv
// Round-robin arbiter that lends one shared countdown timer to a single requester
// at a time; the grant is held while counting, then a one-cycle done pulse follows.
module countdown_arbiter #(
   parameter int NREQ         = 4,
   parameter int CW           = 5,
   parameter int DEFAULT_LOAD = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ*CW-1:0] load_val,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    done,
   output logic [CW-1:0]      count,
   output logic               ready
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW-1:0] LAST_IDX  = IW'(NREQ - 1);
   localparam logic [CW-1:0] ZERO_LOAD = CW'(DEFAULT_LOAD);

   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

   state_t          state, state_next;
   logic [IW-1:0]   winner, winner_next;
   logic [IW-1:0]   last_winner, last_winner_next;
   logic [CW-1:0]   timer, timer_next;
   logic [CW-1:0]   loads [NREQ];
   logic [IW-1:0]   pick, idx;
   logic            found;
   logic [NREQ-1:0] winner_hot;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign loads[g] = load_val[g*CW +: CW];
   end

   // Search starts one past the previous winner and wraps, so every requester gets a turn.
   always_comb begin
      found = 1'b0;
      pick  = last_winner;
      idx   = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = IW'((int'(last_winner) + i) % NREQ);
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end
   end

   always_comb begin
      state_next       = state;
      winner_next      = winner;
      last_winner_next = last_winner;
      timer_next       = timer;
      case (state)
         IDLE: begin
            if (found) begin
               state_next       = COUNT;
               winner_next      = pick;
               last_winner_next = pick;
               timer_next       = (loads[pick] == '0) ? ZERO_LOAD : loads[pick];
            end
         end
         COUNT: begin
            // A dropped request aborts the countdown silently.
            if (!req[winner]) begin
               state_next = IDLE;
               timer_next = '0;
            end else if (timer == '0) begin
               state_next = DONE;
            end else begin
               timer_next = timer - CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
            timer_next = '0;
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         winner      <= LAST_IDX;
         last_winner <= LAST_IDX;
         timer       <= '0;
      end else begin
         state       <= state_next;
         winner      <= winner_next;
         last_winner <= last_winner_next;
         timer       <= timer_next;
      end
   end

   assign winner_hot = NREQ'(1) << winner;
   assign gnt   = (state == COUNT) ? winner_hot : '0;
   assign done  = (state == DONE)  ? winner_hot : '0;
   assign count = (state == COUNT) ? timer : '0;
   assign ready = (state == IDLE);

endmodule

// File: tb/tb_countdown_arbiter.sv
// Self-checking bench for countdown_arbiter: vector table, directed corner sequences
// and randomized traffic compared against a transaction-level reference model.
module tb_countdown_arbiter;

   localparam int NREQ = 4;
   localparam int CW   = 5;
   localparam int DEF  = 8;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [19:0] load_val;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic [4:0]  count;
   logic        ready;

   int checks = 0;
   int errors = 0;

   // Reference model: who owns the timer, who is due a done pulse, remaining count.
   int m_owner;
   int m_done;
   int m_cnt;
   int m_last;

   typedef struct {
      logic        rst_n;
      logic [3:0]  req;
      logic [19:0] lv;
      logic [3:0]  gnt;
      logic [3:0]  done;
      logic [4:0]  count;
      logic        ready;
   } vec_t;

   vec_t vecs[$];

   countdown_arbiter #(.NREQ(NREQ), .CW(CW), .DEFAULT_LOAD(DEF)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .load_val(load_val),
      .gnt(gnt), .done(done), .count(count), .ready(ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [19:0] packLoads(input int l0, input int l1, input int l2, input int l3);
      return {5'(l3), 5'(l2), 5'(l1), 5'(l0)};
   endfunction

   function automatic int loadOf(input logic [19:0] lv, input int i);
      return int'((lv >> (i * CW)) & 20'h1F);
   endfunction

   function automatic int oneHotIdx(input logic [3:0] v);
      for (int i = 0; i < 4; i++) if (v[i]) return i;
      return -1;
   endfunction

   task automatic modelStep(input logic r, input logic [3:0] rq, input logic [19:0] lv);
      int cand;
      if (!r) begin
         m_owner = -1; m_done = -1; m_cnt = 0; m_last = NREQ - 1;
      end else if (m_done >= 0) begin
         m_done = -1;
      end else if (m_owner >= 0) begin
         if (!rq[m_owner]) begin
            m_owner = -1; m_cnt = 0;
         end else if (m_cnt == 0) begin
            m_done = m_owner; m_owner = -1;
         end else begin
            m_cnt = m_cnt - 1;
         end
      end else if (rq != 4'b0000) begin
         for (int i = 1; i <= NREQ; i++) begin
            cand = (m_last + i) % NREQ;
            if (m_owner < 0 && rq[cand]) m_owner = cand;
         end
         m_last = m_owner;
         m_cnt  = loadOf(lv, m_owner);
         if (m_cnt == 0) m_cnt = DEF % (1 << CW);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [19:0] lv);
      @(negedge clk);
      rst_n    = r;
      req      = rq;
      load_val = lv;
      @(posedge clk);
      modelStep(r, rq, lv);
      #1;
   endtask

   task automatic checkOutput(input string name);
      logic [3:0] eg, ed;
      int ec;
      logic er;
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      ed = (m_done >= 0) ? (4'b0001 << m_done) : 4'b0000;
      ec = (m_owner >= 0) ? m_cnt : 0;
      er = (m_owner < 0) && (m_done < 0);
      checks++;
      if (gnt !== eg || done !== ed || int'(count) != ec || ready !== er) begin
         errors++;
         $display("[TB] FAIL %s: got gnt=%b done=%b count=%0d ready=%b, expected gnt=%b done=%b count=%0d ready=%b",
                  name, gnt, done, count, ready, eg, ed, ec, er);
      end
   endtask

   task automatic checkValue(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkVec(input vec_t v, input int i);
      checks++;
      if (gnt !== v.gnt || done !== v.done || count !== v.count || ready !== v.ready) begin
         errors++;
         $display("[TB] FAIL vec%0d: got gnt=%b done=%b count=%0d ready=%b, expected gnt=%b done=%b count=%0d ready=%b",
                  i, gnt, done, count, ready, v.gnt, v.done, v.count, v.ready);
      end
   endtask

   initial begin
      int cyc;
      int last_g;
      int order[$];
      logic [3:0] prev_g;
      logic [3:0] cur_req;
      logic [19:0] lv;
      logic r;

      rst_n = 1'b0; req = 4'b0000; load_val = '0;

      // Single requester with load 3, then a pair where round-robin must skip to 3.
      vecs.push_back('{1'b0, 4'b0000, packLoads(0,0,0,0), 4'b0000, 4'b0000, 5'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b0001, packLoads(3,0,0,0), 4'b0001, 4'b0000, 5'd3, 1'b0});
      vecs.push_back('{1'b1, 4'b0001, packLoads(3,0,0,0), 4'b0001, 4'b0000, 5'd2, 1'b0});
      vecs.push_back('{1'b1, 4'b0001, packLoads(3,0,0,0), 4'b0001, 4'b0000, 5'd1, 1'b0});
      vecs.push_back('{1'b1, 4'b0001, packLoads(3,0,0,0), 4'b0001, 4'b0000, 5'd0, 1'b0});
      vecs.push_back('{1'b1, 4'b0001, packLoads(3,0,0,0), 4'b0000, 4'b0001, 5'd0, 1'b0});
      vecs.push_back('{1'b1, 4'b0000, packLoads(3,0,0,0), 4'b0000, 4'b0000, 5'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b0000, packLoads(3,0,0,0), 4'b0000, 4'b0000, 5'd0, 1'b1});
      vecs.push_back('{1'b1, 4'b1001, packLoads(1,0,0,1), 4'b1000, 4'b0000, 5'd1, 1'b0});
      vecs.push_back('{1'b1, 4'b1001, packLoads(1,0,0,1), 4'b1000, 4'b0000, 5'd0, 1'b0});
      vecs.push_back('{1'b1, 4'b1001, packLoads(1,0,0,1), 4'b0000, 4'b1000, 5'd0, 1'b0});
      vecs.push_back('{1'b1, 4'b0000, packLoads(1,0,0,1), 4'b0000, 4'b0000, 5'd0, 1'b1});

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].rst_n, vecs[i].req, vecs[i].lv);
         checkVec(vecs[i], i);
      end

      // All four requesting with load 1: grants rotate 0,1,2,3,0.
      applyStimulus(1'b0, 4'b0000, '0);
      prev_g = 4'b0000;
      last_g = -1;
      for (int c = 0; c < 40 && order.size() < 5; c++) begin
         applyStimulus(1'b1, 4'b1111, packLoads(1,1,1,1));
         checkOutput("rr_all");
         if (gnt != 4'b0000 && prev_g == 4'b0000) order.push_back(oneHotIdx(gnt));
         if (gnt != 4'b0000) last_g = oneHotIdx(gnt);
         if (done != 4'b0000) checkValue("rr_done_matches_grant", oneHotIdx(done), last_g);
         prev_g = gnt;
      end
      checkValue("rr_grant_count", order.size(), 5);
      for (int i = 0; i < order.size(); i++)
         checkValue($sformatf("rr_order%0d", i), order[i], i % 4);

      // Zero load falls back to 8; done lands 10 cycles after the sampling edge.
      applyStimulus(1'b0, 4'b0000, '0);
      applyStimulus(1'b1, 4'b0100, packLoads(5,6,0,7));
      checkValue("default_load_start", int'(count), 8);
      cyc = 1;
      while (done == 4'b0000 && cyc < 20) begin
         applyStimulus(1'b1, 4'b0100, packLoads(5,6,0,7));
         checkOutput("default_load_run");
         cyc++;
      end
      checkValue("default_load_done_cycle", cyc, 10);
      checkValue("default_load_done_vec", int'(done), 4);

      // Abort: requester 1 drops its request at count 2.
      applyStimulus(1'b0, 4'b0000, '0);
      applyStimulus(1'b1, 4'b0010, packLoads(0,5,0,0));
      checkValue("abort_start_count", int'(count), 5);
      cyc = 0;
      while (count != 5'd2 && cyc < 10) begin
         applyStimulus(1'b1, 4'b0010, packLoads(0,5,0,0));
         cyc++;
      end
      checkValue("abort_reached_2", int'(count), 2);
      applyStimulus(1'b1, 4'b0000, packLoads(0,5,0,0));
      checkValue("abort_ready", int'(ready), 1);
      checkValue("abort_count", int'(count), 0);
      checkValue("abort_gnt", int'(gnt), 0);
      applyStimulus(1'b1, 4'b0000, packLoads(0,5,0,0));
      checkValue("abort_no_done", int'(done), 0);

      // Reset mid-count on requester 3; index 0 has priority afterwards.
      applyStimulus(1'b0, 4'b0000, '0);
      applyStimulus(1'b1, 4'b1000, packLoads(0,0,0,6));
      cyc = 0;
      while (count != 5'd4 && cyc < 10) begin
         applyStimulus(1'b1, 4'b1000, packLoads(0,0,0,6));
         cyc++;
      end
      checkValue("rst_mid_reached_4", int'(count), 4);
      applyStimulus(1'b0, 4'b1001, packLoads(0,0,0,6));
      checkValue("rst_mid_gnt", int'(gnt), 0);
      checkValue("rst_mid_done", int'(done), 0);
      checkValue("rst_mid_count", int'(count), 0);
      checkValue("rst_mid_ready", int'(ready), 1);
      applyStimulus(1'b1, 4'b1001, packLoads(2,0,0,6));
      checkValue("rst_next_gnt", int'(gnt), 1);

      // Reset after granting 1 must restore priority to index 0, so 1010 picks 1 not 3.
      applyStimulus(1'b0, 4'b0000, '0);
      applyStimulus(1'b1, 4'b0010, packLoads(0,6,0,0));
      applyStimulus(1'b1, 4'b0010, packLoads(0,6,0,0));
      applyStimulus(1'b0, 4'b1010, packLoads(0,6,0,6));
      applyStimulus(1'b1, 4'b1010, packLoads(0,6,0,6));
      checkValue("rst_priority_gnt", int'(gnt), 2);

      // Load change during the countdown is ignored; requester 1 wins next.
      applyStimulus(1'b0, 4'b0000, '0);
      applyStimulus(1'b1, 4'b0011, packLoads(2,3,0,0));
      checkValue("ld_change_c2", int'(count), 2);
      checkValue("ld_change_gnt0", int'(gnt), 1);
      applyStimulus(1'b1, 4'b0011, packLoads(7,3,0,0));
      checkValue("ld_change_c1", int'(count), 1);
      applyStimulus(1'b1, 4'b0011, packLoads(7,3,0,0));
      checkValue("ld_change_c0", int'(count), 0);
      applyStimulus(1'b1, 4'b0011, packLoads(7,3,0,0));
      checkValue("ld_change_done", int'(done), 1);
      applyStimulus(1'b1, 4'b0011, packLoads(7,3,0,0));
      checkValue("ld_change_idle", int'(ready), 1);
      applyStimulus(1'b1, 4'b0011, packLoads(7,3,0,0));
      checkValue("ld_change_next_gnt", int'(gnt), 2);
      checkValue("ld_change_next_count", int'(count), 3);

      // Randomized traffic with occasional resets and request changes.
      applyStimulus(1'b0, 4'b0000, '0);
      cur_req = 4'b0000;
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 5) == 0) cur_req = 4'($urandom);
         lv = 20'($urandom);
         if ($urandom_range(0, 3) == 0) lv = '0;
         applyStimulus(r, cur_req, lv);
         checkOutput("random");
         checks++;
         if ((gnt & done) != 4'b0000 || !$onehot0(gnt) || !$onehot0(done)) begin
            errors++;
            $display("[TB] FAIL random_exclusive: got gnt=%b done=%b, expected disjoint one-hot-or-zero", gnt, done);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/countdown_arbiter.md
COUNTDOWN_ARBITER -- requirements
Module: countdown_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the countdown timer.
REQ-002 Parameter CW, default 5: countdown width in bits.
REQ-003 Parameter DEFAULT_LOAD, default 8: load used when the granted requester supplies 0.
REQ-004 clk  input  1: single clock; all state SHALL change on its rising edge only.
REQ-005 rst_n  input  1: reset, synchronous and active-low.
REQ-006 req  input  NREQ: level request per requester; SHALL be held high until done or abort.
REQ-007 load_val  input  NREQ*CW: packed load values; requester i at bits [i*CW +: CW].
REQ-008 gnt  output  NREQ: one-hot grant; zero when no grant is active.
REQ-009 done  output  NREQ: one-cycle pulse to the requester whose countdown reached 0.
REQ-010 count  output  CW: current countdown value.
REQ-011 ready  output  1: high in IDLE only.

Function
REQ-012 States SHALL be IDLE, COUNT and DONE, encoded internally.
REQ-013 IDLE: ready=1, gnt=0, count=0; if req!=0, the block SHALL select a winner and enter COUNT next cycle; otherwise it stays in IDLE.
REQ-014 Arbitration SHALL be round-robin: search begins at index (last_winner+1) mod NREQ and wraps; after reset last_winner=NREQ-1, so index 0 has first priority.
REQ-015 last_winner SHALL update only on the IDLE->COUNT transition.
REQ-016 The winner's load_val SHALL be sampled on the IDLE->COUNT edge; a sampled 0 SHALL be replaced by DEFAULT_LOAD (truncated to CW bits).
REQ-017 COUNT: gnt is one-hot at the winner; count equals load L on the first COUNT cycle and decrements by 1 each cycle; no wrap below 0.
REQ-018 COUNT with count==0 and req[winner]=1: next state DONE.
REQ-019 DONE: done[winner]=1 for exactly one cycle, gnt=0, count=0; next state IDLE unconditionally.
REQ-020 Latency: req sampled in IDLE at cycle 0 -> gnt at cycles 1..L+1 -> done at cycle L+2 -> ready at cycle L+3.
REQ-021 Abort: if req[winner] is 0 in any COUNT cycle, the block SHALL go to IDLE next cycle; done stays 0 and count returns to 0.
REQ-022 Changes to load_val or to non-granted req bits during COUNT/DONE SHALL have no effect.
REQ-023 After DONE or abort, at least one IDLE cycle SHALL occur before the next grant.
REQ-024 The done and gnt vectors SHALL never be high simultaneously, and each SHALL have at most one bit set.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, gnt=0, done=0, count=0, ready=1 and last_winner=NREQ-1, overriding any operation in progress.
REQ-026 Reset asserted mid-COUNT SHALL produce no done pulse; after release, arbitration restarts with index 0 as first priority.

Verification
REQ-027 req=4'b0001, load_val[0]=3 -> gnt=0001 for 4 cycles with count 3,2,1,0; done=0001 one cycle later; ready high the following cycle.
REQ-028 req=4'b1111 held, all loads 1 -> grants in order 0,1,2,3,0; each done pulse matches the preceding grant.
REQ-029 req=4'b0100, load_val[2]=0 -> count starts at 8; done[2] at cycle 10 after the sampling edge.
REQ-030 req=4'b0010, load 5; drop req[1] when count=2 -> IDLE next cycle, no done, count=0, ready=1.
REQ-031 Assert rst_n=0 when count=4 during a grant to requester 3 -> next cycle gnt=0, done=0, count=0, ready=1; with req=4'b1001 the next grant goes to requester 0.
REQ-032 req=4'b0011 with load_val[0]=2; change load_val[0] to 7 while counting -> countdown completes from 2; next grant goes to requester 1.
